zero_seq_tx: RTL and testbench



---
 rtl/zero_seq_tx_pkg.sv | 14 +
 rtl/zero_seq_tx_if.sv | 25 ++
 rtl/zero_seq_tx_pat_shift_reg.sv | 43 ++++
 rtl/zero_seq_tx.sv | 120 ++++++++++++
 tb/tb_zero_seq_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/zero_seq_tx_pkg.sv
// Shared definitions for the zero-sequence transmitter and its matching detectors.
package zero_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } zs_state_e;

  localparam logic       IDLE_LVL  = 1'b1;
  localparam logic [2:0] PAT_ZEROS = 3'b000;

endpackage

// File: rtl/zero_seq_tx_if.sv
// Request/serial-line bundle between a pattern requester and zero_seq_tx.
interface zero_seq_tx_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap_len,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap_len,
    output out, valid, busy, done
  );
endinterface

// File: rtl/zero_seq_tx_pat_shift_reg.sv
// Loadable MSB-first pattern register with a wrapping bit-index down-counter.
module pat_shift_reg #(
  parameter int PAT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  output logic             bit_nxt,
  output logic             last_bit
);
  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;

  // Index wraps to the MSB after bit 0 so the next repetition is already lined up.
  always_comb begin
    pat_nxt = pat_q;
    idx_nxt = idx_q;
    if (load) begin
      pat_nxt = pattern;
      idx_nxt = IDX_TOP;
    end else if (shift) begin
      idx_nxt = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_nxt;
      idx_q <= idx_nxt;
    end
  end

  assign bit_nxt  = pat_nxt[idx_nxt];
  assign last_bit = (idx_q == '0);
endmodule

// File: rtl/zero_seq_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with idle gaps.
//   state   | meaning
//   S_IDLE  | line at idle level, waiting for start
//   S_SHIFT | driving pattern bits, valid=1
//   S_GAP   | idle level between repetitions, still busy
//   S_DONE  | one-cycle done pulse, start ignored
module zero_seq_tx #(
  parameter int   PAT_W    = 3,
  parameter int   CNT_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_LVL = zero_seq_pkg::IDLE_LVL
) (
  input  logic         clock,
  input  logic         reset,
  zero_seq_tx_if.slave bus
);
  import zero_seq_pkg::*;

  zs_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] rep_q, rep_nxt;
  logic [GAP_W-1:0] gap_len_q, gap_len_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic             load, shift, bit_nxt, last_bit;
  logic             out_q, valid_q, busy_q, done_q;
  logic             out_nxt, valid_nxt, busy_nxt, done_nxt;

  pat_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .pattern  (bus.pattern),
    .bit_nxt  (bit_nxt),
    .last_bit (last_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_q     <= '0;
      out_q     <= IDLE_LVL;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rep_q     <= rep_nxt;
      gap_len_q <= gap_len_nxt;
      gap_q     <= gap_nxt;
      out_q     <= out_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    rep_nxt     = rep_q;
    gap_len_nxt = gap_len_q;
    gap_nxt     = gap_q;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load        = 1'b1;
          rep_nxt     = bus.repeat_cnt;
          gap_len_nxt = bus.gap_len;
          state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          if (rep_q == '0) begin
            state_nxt = S_DONE;
          end else begin
            rep_nxt = rep_q - 1'b1;
            if (gap_len_q != '0) begin
              gap_nxt   = gap_len_q;
              state_nxt = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        gap_nxt = gap_q - 1'b1;
        if (gap_q == GAP_W'(1)) state_nxt = S_SHIFT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with it.
  always_comb begin
    out_nxt   = IDLE_LVL;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      S_SHIFT: begin
        out_nxt   = bit_nxt;
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_GAP:   busy_nxt = 1'b1;
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_zero_seq_tx.sv
// Bench for zero_seq_tx: per-cycle comparison against an expected line trace built from the send rules.
module tb_zero_seq_tx;
  import zero_seq_pkg::*;

  localparam int PAT_W = 3;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic clock;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  zero_seq_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  zero_seq_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] line_now();
    return {bus.out, bus.valid, bus.busy, bus.done};
  endfunction

  // mode 0: inputs quiet after start; 1: random noise on all inputs; 2: one competing start at the third bit
  task automatic run_transfer(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                              input logic [GAP_W-1:0] g, input int mode, input string name);
    logic [3:0] exp_q[$];
    logic [3:0] got;
    int         ri, gi;
    ri = int'(r);
    gi = int'(g);
    for (int s = 0; s <= ri; s++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (s < ri) for (int k = 0; k < gi; k++) exp_q.push_back(4'b1010);
    end
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b1000);

    @(negedge clock);
    bus.start      = 1'b1;
    bus.pattern    = p;
    bus.repeat_cnt = r;
    bus.gap_len    = g;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      got = line_now();
      tests++;
      if (got !== exp_q[i]) begin
        failed++;
        $display("FAIL %s cycle %0d: out/valid/busy/done got %b expected %b", name, i, got, exp_q[i]);
      end
      if (i == exp_q.size() - 1) begin
        bus.start = 1'b0;
      end else if (mode == 1) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.pattern    = PAT_W'($urandom);
        bus.repeat_cnt = CNT_W'($urandom);
        bus.gap_len    = GAP_W'($urandom);
      end else if (mode == 2 && i == 2) begin
        bus.start   = 1'b1;
        bus.pattern = ~p;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if (line_now() !== 4'b1000) begin
        failed++;
        $display("FAIL reset_hold cycle %0d: got %b expected 1000", i, line_now());
      end
    end
    bus.start = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (line_now() !== 4'b1000) begin
        failed++;
        $display("FAIL reset_release cycle %0d: got %b expected 1000", i, line_now());
      end
    end
  endtask

  task automatic test_single();
    run_transfer(PAT_ZEROS, 4'd0, GAP_W'($urandom), 0, "single_000");
  endtask

  task automatic test_repeat_gap();
    run_transfer(3'b101, 4'd2, 4'd2, 0, "repeat_gap_101");
  endtask

  task automatic test_back_to_back();
    run_transfer(3'b000, 4'd1, 4'd0, 0, "back_to_back");
    run_transfer(3'b110, 4'd3, 4'd0, 1, "back_to_back_noise");
  endtask

  task automatic test_start_while_busy();
    run_transfer(3'b011, 4'd0, 4'd0, 2, "start_while_busy");
    run_transfer(3'b100, 4'd1, 4'd3, 2, "start_while_busy_rep");
  endtask

  task automatic test_max_counts();
    run_transfer(PAT_W'($urandom), 4'hF, 4'hF, 1, "max_counts");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_transfer(PAT_W'($urandom), CNT_W'($urandom_range(0, 5)),
                   GAP_W'($urandom_range(0, 4)), 1, "random");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.start      = 1'b1;
    bus.pattern    = 3'b010;
    bus.repeat_cnt = 4'd3;
    bus.gap_len    = 4'd1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    tests++;
    if (line_now() !== 4'b1110) begin
      failed++;
      $display("FAIL reset_mid_pre: got %b expected 1110", line_now());
    end
    #1 reset = 1'b0;
    #1;
    tests++;
    if (line_now() !== 4'b1000) begin
      failed++;
      $display("FAIL reset_mid_async: got %b expected 1000", line_now());
    end
    @(negedge clock);
    tests++;
    if (line_now() !== 4'b1000) begin
      failed++;
      $display("FAIL reset_mid_held: got %b expected 1000", line_now());
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (line_now() !== 4'b1000) begin
      failed++;
      $display("FAIL reset_mid_release: got %b expected 1000", line_now());
    end
    run_transfer(3'b100, 4'd0, 4'd0, 0, "after_reset_mid");
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    bus.gap_len    = '0;
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_start_while_busy();
    test_max_counts();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
